// File: rtl/piso_framer.sv
// rtl/piso_framer.sv - word-to-bit framer feeding the SISO chain, optional idle gap between frames
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_framer #(
  parameter int   WIDTH      = 5,
  parameter int   MSB_FIRST  = 0,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic             so_n, so_valid_n, frame_start_n, busy_n;
  logic             last, accept, next_bit;

  function automatic logic first_bit(input logic [WIDTH-1:0] x);
    return (MSB_FIRST != 0) ? x[WIDTH-1] : x[0];
  endfunction

  // Drops the bit just sent so the next one sits in the first-bit position.
  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] x);
    return (MSB_FIRST != 0) ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
  endfunction

  assign last      = (cnt == LAST_IDX);
  assign din_ready = (state == IDLE) || (state == SHIFT && last && GAP_CYCLES == 0);
  assign accept    = din_valid && din_ready;

`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  logic par, par_n;

  always_comb begin
    par_n    = accept ? ^din : par;
    next_bit = (cnt == DATA_LAST) ? par : first_bit(sreg);
  end
`else
  always_comb begin
    next_bit = first_bit(sreg);
  end
`endif

  always_comb begin
    state_n       = state;
    sreg_n        = sreg;
    cnt_n         = cnt;
    gap_cnt_n     = gap_cnt;
    so_n          = IDLE_LEVEL;
    so_valid_n    = 1'b0;
    frame_start_n = 1'b0;

    case (state)
      SHIFT: begin
        if (!last) begin
          cnt_n      = cnt + 1'b1;
          so_n       = next_bit;
          so_valid_n = 1'b1;
          sreg_n     = shifted(sreg);
        end else if (GAP_CYCLES > 0) begin
          state_n   = GAP;
          gap_cnt_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
        else gap_cnt_n = gap_cnt + 1'b1;
      end
      default: ;
    endcase

    // A word can only be taken from IDLE or, with no gap, on the last bit.
    if (accept) begin
      state_n       = SHIFT;
      sreg_n        = shifted(din);
      cnt_n         = '0;
      so_n          = first_bit(din);
      so_valid_n    = 1'b1;
      frame_start_n = 1'b1;
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      so          <= IDLE_LEVEL;
      so_valid    <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
`ifdef PISO_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      sreg        <= sreg_n;
      cnt         <= cnt_n;
      gap_cnt     <= gap_cnt_n;
      so          <= so_n;
      so_valid    <= so_valid_n;
      frame_start <= frame_start_n;
      busy        <= busy_n;
`ifdef PISO_PARITY_EN
      par         <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_piso_framer.sv
// tb/tb_piso_framer.sv - directed bench for piso_framer: LSB/MSB order, gap, back-to-back, reset abort
// Frame length and trailing bit follow PISO_PARITY_EN when it is defined.
module tb_piso_framer;

`ifdef PISO_PARITY_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] din_a = '0, din_b = '0, din_c = '0;
  logic       val_a = 1'b0, val_b = 1'b0, val_c = 1'b0;
  logic       rdy_a, so_a, sv_a, fs_a, busy_a;
  logic       rdy_b, so_b, sv_b, fs_b, busy_b;
  logic       rdy_c, so_c, sv_c, fs_c, busy_c;

  int checks = 0;
  int failures = 0;
  logic [4:0] w;

  always #5 clk = ~clk;

  piso_framer #(.WIDTH(5), .MSB_FIRST(0), .IDLE_LEVEL(1'b0), .GAP_CYCLES(1)) u_lsb (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(val_a), .din_ready(rdy_a),
    .so(so_a), .so_valid(sv_a), .frame_start(fs_a), .busy(busy_a));

  piso_framer #(.WIDTH(5), .MSB_FIRST(1), .IDLE_LEVEL(1'b0), .GAP_CYCLES(1)) u_msb (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(val_b), .din_ready(rdy_b),
    .so(so_b), .so_valid(sv_b), .frame_start(fs_b), .busy(busy_b));

  piso_framer #(.WIDTH(5), .MSB_FIRST(0), .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .rst(rst), .din(din_c), .din_valid(val_c), .din_ready(rdy_c),
    .so(so_c), .so_valid(sv_c), .frame_start(fs_c), .busy(busy_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of a frame as it should appear on so; index 5 is the even-parity bit.
  function automatic logic exp_bit(input logic [4:0] word, input int i, input bit msb);
    if (i >= 5) return ^word;
    return msb ? word[4 - i] : word[i];
  endfunction

  initial begin
    // Reset held for two cycles
    tick();
    tick();
    chk("rst_so", so_a, 0);
    chk("rst_so_valid", sv_a, 0);
    chk("rst_frame_start", fs_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_so_valid_gap0", sv_c, 0);
    rst = 1'b0;
    #1;
    chk("rst_din_ready", rdy_a, 1);

    // LSB-first frame, competing word held during the frame, one gap cycle
    w = 5'b10110;
    din_a = w;
    val_a = 1'b1;
    tick();
    din_a = 5'h1F;
    for (int c = 1; c <= NB; c++) begin
      chk($sformatf("lsb_so_c%0d", c), so_a, exp_bit(w, c - 1, 1'b0));
      chk($sformatf("lsb_so_valid_c%0d", c), sv_a, 1);
      chk($sformatf("lsb_frame_start_c%0d", c), fs_a, (c == 1));
      chk($sformatf("lsb_busy_c%0d", c), busy_a, 1);
      chk($sformatf("lsb_din_ready_c%0d", c), rdy_a, 0);
      tick();
    end
    chk("lsb_gap_so_valid", sv_a, 0);
    chk("lsb_gap_so", so_a, 0);
    chk("lsb_gap_busy", busy_a, 1);
    chk("lsb_gap_din_ready", rdy_a, 0);
    tick();
    chk("lsb_after_gap_busy", busy_a, 0);
    chk("lsb_after_gap_din_ready", rdy_a, 1);
    chk("lsb_after_gap_so_valid", sv_a, 0);
    val_a = 1'b0;
    tick();

    // MSB-first frame
    w = 5'b10110;
    din_b = w;
    val_b = 1'b1;
    tick();
    val_b = 1'b0;
    for (int c = 1; c <= NB; c++) begin
      chk($sformatf("msb_so_c%0d", c), so_b, exp_bit(w, c - 1, 1'b1));
      chk($sformatf("msb_so_valid_c%0d", c), sv_b, 1);
      tick();
    end
    chk("msb_end_so_valid", sv_b, 0);
    tick();

    // No gap: back-to-back frames 0x1F then 0x00
    din_c = 5'h1F;
    val_c = 1'b1;
    tick();
    for (int c = 1; c <= 2 * NB; c++) begin
      if (c == NB) din_c = 5'h00;
      if (c == NB + 1) val_c = 1'b0;
      chk($sformatf("b2b_so_c%0d", c), so_c,
          (c <= NB) ? exp_bit(5'h1F, c - 1, 1'b0) : exp_bit(5'h00, c - NB - 1, 1'b0));
      chk($sformatf("b2b_so_valid_c%0d", c), sv_c, 1);
      chk($sformatf("b2b_frame_start_c%0d", c), fs_c, (c == 1 || c == NB + 1));
      chk($sformatf("b2b_din_ready_c%0d", c), rdy_c, (c == NB || c == 2 * NB));
      tick();
    end
    chk("b2b_end_so_valid", sv_c, 0);
    chk("b2b_end_busy", busy_c, 0);

    // Reset on cycle 3 of a 0x1F frame aborts it
    din_a = 5'h1F;
    val_a = 1'b1;
    tick();
    val_a = 1'b0;
    tick();
    tick();
    chk("abort_c3_so", so_a, 1);
    chk("abort_c3_so_valid", sv_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_so", so_a, 0);
    chk("abort_so_valid", sv_a, 0);
    chk("abort_frame_start", fs_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_din_ready", rdy_a, 1);
    w = 5'b00001;
    din_a = w;
    val_a = 1'b1;
    tick();
    val_a = 1'b0;
    for (int c = 1; c <= NB; c++) begin
      chk($sformatf("post_abort_so_c%0d", c), so_a, exp_bit(w, c - 1, 1'b0));
      chk($sformatf("post_abort_so_valid_c%0d", c), sv_a, 1);
      chk($sformatf("post_abort_frame_start_c%0d", c), fs_a, (c == 1));
      tick();
    end
    tick();
    chk("idle_again_din_ready", rdy_a, 1);

    // Reset and din_valid together: reset wins, word not taken
    din_a = 5'h1F;
    val_a = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    val_a = 1'b0;
    #1;
    chk("rst_vs_valid_so_valid", sv_a, 0);
    chk("rst_vs_valid_busy", busy_a, 0);
    tick();
    chk("rst_vs_valid_next_so_valid", sv_a, 0);
    chk("rst_vs_valid_next_busy", busy_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
